// File: rtl/thermo_level_encoder_pkg.sv
// Shared types, constants and helpers for the thermometer-to-level encoder.
// Latency: n/a (pure declarations and combinational functions).
// Backpressure: none; consumers evaluate these helpers combinationally.
package thermo_level_encoder_pkg;

    localparam logic [7:0] LEVEL_STEP = 8'h20;
    localparam int         N_SEGS     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Segment count 0..8 to bar-graph level: 0 -> 00, k -> 32*k-1 (9-bit math, truncated).
    function automatic logic [7:0] seg_to_level(input logic [3:0] n);
        logic [8:0] t;
        if (n == 4'd0) begin
            t = 9'd0;
        end else begin
            t = 9'(n) * 9'(LEVEL_STEP) - 9'd1;
        end
        return t[7:0];
    endfunction

    // Contiguous ones from bit0 (including all-zero): adding one clears every set bit.
    function automatic logic is_thermo(input logic [N_SEGS-1:0] code);
        logic [N_SEGS-1:0] inc;
        inc = code + N_SEGS'(1);
        return ((code & inc) == '0);
    endfunction

    // Number of set bits; equals the segment count for valid codes.
    function automatic logic [3:0] count_ones(input logic [N_SEGS-1:0] code);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < N_SEGS; i++) begin
            c = c + 4'(code[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/thermo_level_encoder_if.sv
// Bundle of the thermometer input and the committed level outputs.
// Latency: n/a (wiring only).
// Backpressure: none; level_valid is a fire-and-forget one-cycle pulse.
interface thermo_level_encoder_if;
    import thermo_level_encoder_pkg::*;

    logic [N_SEGS-1:0] therm;
    logic [7:0]        level;
    logic              level_valid;
    logic              bubble_err;
    logic [3:0]        seg_count;

    // Front-end side: drives the raw code, observes the result.
    modport master (
        output therm,
        input  level,
        input  level_valid,
        input  bubble_err,
        input  seg_count
    );

    // Encoder side.
    modport slave (
        input  therm,
        output level,
        output level_valid,
        output bubble_err,
        output seg_count
    );
endinterface

// File: rtl/thermo_level_encoder_sync_ff_chain.sv
// Multi-flop synchronizer for an asynchronous bus (bits are synchronized independently).
// Latency: DEPTH cycles from d_i to q_o.
// Backpressure: none; samples every cycle.
module sync_ff_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [DEPTH];

    // Shift the raw input through DEPTH flops; all stages clear on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/thermo_level_encoder.sv
// Thermometer code -> debounced bar-graph level; optional popcount bubble repair (THERMO_BUBBLE_FIX_EN).
// Latency: SYNC_STAGES + STABLE_CYCLES + 1 cycles from first sampling edge to new level/level_valid.
// Backpressure: none; level_valid is a single-cycle pulse, never two in a row.
module thermo_level_encoder
    import thermo_level_encoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input logic                 clk,
    input logic                 reset,
    thermo_level_encoder_if.slave bus
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [N_SEGS-1:0] s;
    logic [3:0]        n_s;
    logic              s_thermo;
    logic              sample_ok;

    state_t            state_q, state_d;
    logic [3:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [7:0]        level_q, level_d;
    logic [3:0]        seg_q, seg_d;
    logic              lv_q, lv_d;
    logic              bubble_q, bubble_d;

    sync_ff_chain #(
        .WIDTH (N_SEGS),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.therm),
        .q_o   (s)
    );

    assign s_thermo = is_thermo(s);
    // For valid codes popcount is the segment count; for bubbles it is the repaired count.
    assign n_s      = count_ones(s);
`ifdef THERMO_BUBBLE_FIX_EN
    // Repaired bubbles debounce like any other sample.
    assign sample_ok = 1'b1;
`else
    // Bubbled samples are ignored entirely by the debouncer.
    assign sample_ok = s_thermo;
`endif

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // FSM state register plus debounce bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: track a candidate count until it has been stable long enough.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sample_ok && (n_s != seg_q)) begin
                    cand_d  = n_s;
                    cnt_d   = CNT_W'(1);
                    state_d = (STABLE_CYCLES == 1) ? COMMIT : SETTLE;
                end
            end
            SETTLE: begin
                if (sample_ok) begin
                    if (n_s == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_d = COMMIT;
                        end
                    end else if (n_s == seg_q) begin
                        // Input fell back to the committed value: the excursion was a glitch.
                        state_d = IDLE;
                    end else begin
                        cand_d = n_s;
                        cnt_d  = CNT_W'(1);
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output next-values: commit the candidate only while in COMMIT; bubbles latch the error.
    always_comb begin
        level_d  = level_q;
        seg_d    = seg_q;
        lv_d     = 1'b0;
        bubble_d = bubble_q | ~s_thermo;
        if (state_q == COMMIT) begin
            level_d = seg_to_level(cand_q);
            seg_d   = cand_q;
            lv_d    = 1'b1;
        end
    end

    // Registered outputs so level and level_valid change on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q  <= 8'h00;
            seg_q    <= 4'd0;
            lv_q     <= 1'b0;
            bubble_q <= 1'b0;
        end else begin
            level_q  <= level_d;
            seg_q    <= seg_d;
            lv_q     <= lv_d;
            bubble_q <= bubble_d;
        end
    end

    assign bus.level       = level_q;
    assign bus.seg_count   = seg_q;
    assign bus.level_valid = lv_q;
    assign bus.bubble_err  = bubble_q;

endmodule

// File: tb/tb_thermo_level_encoder.sv
// Directed bench for thermo_level_encoder with default parameters.
// Latency: checks the 19-cycle step-to-level delay and pulse counts.
// Backpressure: none; every wait is a fixed cycle count.
module tb_thermo_level_encoder;

    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;
    int lat;
    int pulses;

    thermo_level_encoder_if bus ();

    thermo_level_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive a code and run ncyc edges, recording the edge index of the first pulse and the pulse count.
    task automatic apply(input logic [7:0] t, input int ncyc, output int first, output int npulse);
        bus.therm = t;
        first  = -1;
        npulse = 0;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            if (bus.level_valid === 1'b1) begin
                npulse++;
                if (first < 0) first = k;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.therm = 8'h00;
        repeat (3) tick();
        check("rst_level", bus.level, 8'h00);
        check("rst_seg", bus.seg_count, 4'd0);
        check("rst_valid", bus.level_valid, 1'b0);
        check("rst_bubble", bus.bubble_err, 1'b0);
        reset = 1'b0;
        repeat (3) tick();

        // Clean step to 0F: level stays 00 until edge 19, then 7F with one pulse.
        bus.therm = 8'h0F;
        for (int k = 1; k <= 24; k++) begin
            tick();
            check("step_valid", bus.level_valid, (k == 19) ? 1 : 0);
            check("step_level", bus.level, (k >= 19) ? 8'h7F : 8'h00);
        end
        check("step_seg", bus.seg_count, 4'd4);

        // Short excursion to 1F and back is rejected.
        bus.therm = 8'h1F;
        repeat (5) tick();
        apply(8'h0F, 30, lat, pulses);
        check("glitch_pulses", pulses, 0);
        check("glitch_level", bus.level, 8'h7F);

        // Full scale and back to zero.
        apply(8'hFF, 30, lat, pulses);
        check("ff_lat", lat, 19);
        check("ff_pulses", pulses, 1);
        check("ff_level", bus.level, 8'hFF);
        check("ff_seg", bus.seg_count, 4'd8);
        apply(8'h00, 30, lat, pulses);
        check("zero_lat", lat, 19);
        check("zero_pulses", pulses, 1);
        check("zero_level", bus.level, 8'h00);
        check("zero_seg", bus.seg_count, 4'd0);

        // Bubbled code 0B.
        apply(8'h0B, 40, lat, pulses);
        check("bub_err", bus.bubble_err, 1'b1);
`ifdef THERMO_BUBBLE_FIX_EN
        check("bub_pulses", pulses, 1);
        check("bub_level", bus.level, 8'h5F);
        check("bub_seg", bus.seg_count, 4'd3);
`else
        check("bub_pulses", pulses, 0);
        check("bub_level", bus.level, 8'h00);
        check("bub_seg", bus.seg_count, 4'd0);
`endif
        apply(8'h07, 40, lat, pulses);
`ifdef THERMO_BUBBLE_FIX_EN
        check("after_bub_pulses", pulses, 0);
`else
        check("after_bub_lat", lat, 19);
        check("after_bub_pulses", pulses, 1);
`endif
        check("after_bub_level", bus.level, 8'h5F);
        check("after_bub_seg", bus.seg_count, 4'd3);
        check("after_bub_err", bus.bubble_err, 1'b1);

        // Reset in the middle of settling toward 3F.
        bus.therm = 8'h3F;
        repeat (8) tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("midrst_level", bus.level, 8'h00);
            check("midrst_seg", bus.seg_count, 4'd0);
            check("midrst_valid", bus.level_valid, 1'b0);
            check("midrst_bubble", bus.bubble_err, 1'b0);
        end
        reset = 1'b0;
        apply(8'h3F, 30, lat, pulses);
        check("post_rst_lat", lat, 19);
        check("post_rst_pulses", pulses, 1);
        check("post_rst_level", bus.level, 8'hBF);
        check("post_rst_seg", bus.seg_count, 4'd6);
        check("post_rst_bubble", bus.bubble_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
